// File: rtl/gomoku_pkg.sv
// Shared types and palette for the gomoku display path.
// Cell codes, 12-bit colour struct, fixed colours.
package gomoku_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BLACK = 2'd1,
    WHITE = 2'd2
  } cell_e;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb12_t;

  localparam rgb12_t COL_OFF    = 12'h000;
  localparam rgb12_t COL_BG     = 12'h234;
  localparam rgb12_t COL_WOOD   = 12'hC90;
  localparam rgb12_t COL_GRID   = 12'h000;
  localparam rgb12_t COL_BLACK  = 12'h111;
  localparam rgb12_t COL_WHITE  = 12'hFFF;
  localparam rgb12_t COL_CURSOR = 12'hF00;

endpackage

// File: rtl/gomoku_board_renderer_cell_tracker.sv
// Tracks cell index and in-cell offset along one raster axis.
// Next-state index is exported so the board RAM sees it a clock early.
module cell_tracker
  import gomoku_pkg::*;
#(
  parameter int ORIGIN  = 110,
  parameter int CELL_PX = 28,
  parameter int BOARD_N = 15,
  localparam int IW = $clog2(BOARD_N),
  localparam int OW = $clog2(CELL_PX)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stb_i,
  input  logic [9:0]    cnt_i,
  output logic [IW-1:0] idx_d_o,
  output logic [IW-1:0] idx_q_o,
  output logic [OW-1:0] off_q_o,
  output logic          vld_q_o
);

  logic [IW-1:0] idx_q, idx_d;
  logic [OW-1:0] off_q, off_d;
  logic          vld_q, vld_d;

  always_comb begin
    idx_d = idx_q;
    off_d = off_q;
    vld_d = vld_q;
    if (stb_i) begin
      if (cnt_i == '0) begin
        vld_d = 1'b0;
      end else if (cnt_i == 10'(ORIGIN)) begin
        idx_d = '0;
        off_d = '0;
        vld_d = 1'b1;
      end else if (vld_q) begin
        if (off_q == OW'(CELL_PX - 1)) begin
          off_d = '0;
          if (idx_q == IW'(BOARD_N - 1)) vld_d = 1'b0;
          else idx_d = idx_q + 1'b1;
        end else begin
          off_d = off_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q <= '0;
      off_q <= '0;
      vld_q <= 1'b0;
    end else begin
      idx_q <= idx_d;
      off_q <= off_d;
      vld_q <= vld_d;
    end
  end

  assign idx_d_o = idx_d;
  assign idx_q_o = idx_q;
  assign off_q_o = off_q;
  assign vld_q_o = vld_q;

endmodule

// File: rtl/gomoku_board_renderer.sv
// Gomoku board pixel renderer: 3-stage stall-able pipeline
// producing grid, stones and blinking cursor, with matched syncs.
module gomoku_board_renderer
  import gomoku_pkg::*;
#(
  parameter int BOARD_N      = 15,
  parameter int CELL_PX      = 28,
  parameter int ORIGIN_X     = 110,
  parameter int ORIGIN_Y     = 30,
  parameter int STONE_R      = 11,
  parameter int BLINK_FRAMES = 30,
  localparam int AW = $clog2(BOARD_N * BOARD_N),
  localparam int IW = $clog2(BOARD_N)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_en,
  input  logic          valid_in,
  input  logic [9:0]    h_cnt,
  input  logic [9:0]    v_cnt,
  input  logic          hsync_in,
  input  logic          vsync_in,
  output logic [AW-1:0] board_addr,
  input  logic [1:0]    board_data,
  input  logic          cursor_en,
  input  logic [IW-1:0] cursor_row,
  input  logic [IW-1:0] cursor_col,
  output logic [3:0]    vga_red,
  output logic [3:0]    vga_grn,
  output logic [3:0]    vga_blu,
  output logic          hsync,
  output logic          vsync
);

  localparam int OW = $clog2(CELL_PX);
  localparam int FW = $clog2(BLINK_FRAMES + 1);
  localparam logic [OW-1:0] OFF_LAST = OW'(CELL_PX - 1);
  localparam logic [OW-1:0] OFF_RING = OW'(CELL_PX - 2);
  localparam logic signed [5:0] HALF = 6'(CELL_PX / 2);
  localparam logic [11:0] R2 = 12'(STONE_R * STONE_R);

  // S1: tracker state lives inside the trackers
  logic [IW-1:0] col_d, col_q, row_d, row_q;
  logic [OW-1:0] xoff_q, yoff_q;
  logic          col_vld_q, row_vld_q;
  logic          row_stb;

  assign row_stb = pix_en & (h_cnt == '0);

  cell_tracker #(
    .ORIGIN (ORIGIN_X),
    .CELL_PX(CELL_PX),
    .BOARD_N(BOARD_N)
  ) u_col (
    .clk    (clk),
    .rst    (rst),
    .stb_i  (pix_en),
    .cnt_i  (h_cnt),
    .idx_d_o(col_d),
    .idx_q_o(col_q),
    .off_q_o(xoff_q),
    .vld_q_o(col_vld_q)
  );

  cell_tracker #(
    .ORIGIN (ORIGIN_Y),
    .CELL_PX(CELL_PX),
    .BOARD_N(BOARD_N)
  ) u_row (
    .clk    (clk),
    .rst    (rst),
    .stb_i  (row_stb),
    .cnt_i  (v_cnt),
    .idx_d_o(row_d),
    .idx_q_o(row_q),
    .off_q_o(yoff_q),
    .vld_q_o(row_vld_q)
  );

  // RAM registers this alongside S1, so data is ready for S2
  assign board_addr = AW'(row_d) * AW'(BOARD_N) + AW'(col_d);

  logic s1_vld_q, s1_hs_q, s1_vs_q;

  // Blink phase
  logic          vs_prev_q, phase_q;
  logic [FW-1:0] frame_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      vs_prev_q <= 1'b1;
      frame_q   <= '0;
      phase_q   <= 1'b0;
    end else if (pix_en) begin
      vs_prev_q <= vsync_in;
      if (!vs_prev_q && vsync_in) begin
        if (frame_q == FW'(BLINK_FRAMES - 1)) begin
          frame_q <= '0;
          phase_q <= ~phase_q;
        end else begin
          frame_q <= frame_q + 1'b1;
        end
      end
    end
  end

  // S2 flags from S1 state
  logic signed [5:0]  dx, dy;
  logic signed [11:0] dx2, dy2;
  logic [11:0]        d2;
  logic               ring, cur_hit, stone_hit, grid_hit;

  assign dx  = $signed(6'(xoff_q)) - HALF;
  assign dy  = $signed(6'(yoff_q)) - HALF;
  assign dx2 = 12'(dx) * 12'(dx);
  assign dy2 = 12'(dy) * 12'(dy);
  assign d2  = $unsigned(dx2) + $unsigned(dy2);
  assign stone_hit = (d2 <= R2);

  assign ring = (xoff_q == OW'(1)) | (xoff_q == OFF_RING) |
                (yoff_q == OW'(1)) | (yoff_q == OFF_RING);
  assign cur_hit = cursor_en & ~phase_q & ring &
                   (row_q == cursor_row) & (col_q == cursor_col);
  assign grid_hit = (xoff_q == '0) | (yoff_q == '0) |
                    ((col_q == IW'(BOARD_N - 1)) & (xoff_q == OFF_LAST)) |
                    ((row_q == IW'(BOARD_N - 1)) & (yoff_q == OFF_LAST));

  logic       s2_vld_q, s2_hs_q, s2_vs_q, s2_inb_q;
  logic       s2_cur_q, s2_stone_q, s2_grid_q;
  logic [1:0] s2_cell_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q   <= 1'b0;
      s1_hs_q    <= 1'b1;
      s1_vs_q    <= 1'b1;
      s2_vld_q   <= 1'b0;
      s2_hs_q    <= 1'b1;
      s2_vs_q    <= 1'b1;
      s2_inb_q   <= 1'b0;
      s2_cur_q   <= 1'b0;
      s2_stone_q <= 1'b0;
      s2_grid_q  <= 1'b0;
      s2_cell_q  <= '0;
    end else if (pix_en) begin
      s1_vld_q   <= valid_in;
      s1_hs_q    <= hsync_in;
      s1_vs_q    <= vsync_in;
      s2_vld_q   <= s1_vld_q;
      s2_hs_q    <= s1_hs_q;
      s2_vs_q    <= s1_vs_q;
      s2_inb_q   <= col_vld_q & row_vld_q;
      s2_cur_q   <= cur_hit;
      s2_stone_q <= stone_hit;
      s2_grid_q  <= grid_hit;
      s2_cell_q  <= board_data;
    end
  end

  // S3 colour mux, highest priority first
  rgb12_t pix_d, pix_q;
  logic   hs_q, vs_q;

  always_comb begin
    pix_d = COL_WOOD;
    if (!s2_vld_q) pix_d = COL_OFF;
    else if (!s2_inb_q) pix_d = COL_BG;
    else if (s2_cur_q) pix_d = COL_CURSOR;
    else if (s2_stone_q && s2_cell_q == BLACK) pix_d = COL_BLACK;
    else if (s2_stone_q && s2_cell_q == WHITE) pix_d = COL_WHITE;
    else if (s2_grid_q) pix_d = COL_GRID;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pix_q <= COL_OFF;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
    end else if (pix_en) begin
      pix_q <= pix_d;
      hs_q  <= s2_hs_q;
      vs_q  <= s2_vs_q;
    end
  end

  assign vga_red = pix_q.r;
  assign vga_grn = pix_q.g;
  assign vga_blu = pix_q.b;
  assign hsync   = hs_q;
  assign vsync   = vs_q;

endmodule

// File: doc/gomoku_board_renderer.md
# gomoku_board_renderer

Parametrised pixel renderer for the gomoku display path. It sits between the VGA timing generator and the colour pins. From the h/v counters it produces an N×N board with grid lines, round black and white stones read from an external board RAM, and a blinking cursor. It replaces the fixed column-only pixel generator with a stall-able 3-stage pipeline that also delays sync to match.

## Interface
Parameters:
- BOARD_N, 15: cells per side
- CELL_PX, 28: cell size in pixels (≥ 8)
- ORIGIN_X, 110: h_cnt of the board's left edge
- ORIGIN_Y, 30: v_cnt of the board's top edge
- STONE_R, 11: stone radius in pixels
- BLINK_FRAMES, 30: frames per cursor blink phase

Ports:
- clk  in  1  system clock; one clock, all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- pix_en  in  1  pixel strobe; the pipeline and all counters advance only when it is 1
- valid_in  in  1  active-video flag from the timing generator
- h_cnt  in  10  pixel column, 0..639
- v_cnt  in  10  pixel row, 0..479
- hsync_in, vsync_in  in  1 each  active-low syncs from the timing generator
- board_addr  out  $clog2(BOARD_N²)  board RAM address, row*BOARD_N+col
- board_data  in  2  RAM read data; 1-clk latency, held while the address is stable
- cursor_en  in  1  cursor display enable
- cursor_row, cursor_col  in  $clog2(BOARD_N) each  cursor cell
- vga_red, vga_grn, vga_blu  out  4 each  colour
- hsync, vsync  out  1 each  syncs delayed to align with the colour outputs

## Operation
- All counters update only on pix_en=1.
- Column tracker:
  - h_cnt==0 clears col_valid.
  - h_cnt==ORIGIN_X sets col=0, xoff=0, col_valid=1.
  - Otherwise, while col_valid: xoff++. When xoff==CELL_PX-1, xoff wraps to 0 and col++. When col would reach BOARD_N, col_valid clears.
- Row tracker: the same scheme evaluated only when h_cnt==0.
  - v_cnt==0 clears row_valid.
  - v_cnt==ORIGIN_Y sets row=0, yoff=0, row_valid=1.
  - Otherwise, while row_valid: yoff++ with wrap at CELL_PX; row_valid clears after row BOARD_N-1.
- in_board = col_valid & row_valid.
- Pixel classes, highest priority first:
  1. valid=0: colour 0x000.
  2. !in_board: background 0x234.
  3. Cursor: cursor_en, phase=0, (row,col)==cursor, and xoff or yoff ∈ {1, CELL_PX-2}: 0xF00.
  4. Stone: dx=xoff-CELL_PX/2 and dy=yoff-CELL_PX/2, both signed. If dx²+dy² ≤ STONE_R², board_data 1 gives 0x111 and 2 gives 0xFFF. Value 0 is empty; value 3 is treated as empty.
  5. Grid: xoff==0, or yoff==0, or (col==BOARD_N-1 & xoff==CELL_PX-1), or (row==BOARD_N-1 & yoff==CELL_PX-1): 0x000.
  6. Otherwise wood 0xC90.
- The square computation uses 6-bit signed operands and a 12-bit unsigned sum.
- Blink:
  - A frame tick is a vsync_in 0→1 edge sampled on pix_en.
  - frame_cnt counts 0..BLINK_FRAMES-1. Phase toggles when it wraps.
- Cursor row or column ≥ BOARD_N means no cursor is drawn.

## Timing
- Pipeline stages, all advancing on pix_en:
  - S1: register tracker state; drive board_addr.
  - S2: capture board_data; compute dx²+dy² and the flags.
  - S3: colour mux into the output registers.
- Latency from valid_in, h_cnt and v_cnt to colour is exactly 3 pix_en strobes.
- hsync, vsync and valid are delayed by the same 3 stages.
- pix_en gaps hold all state. board_addr stays stable across a gap, so board_data is still valid afterwards.
- Reset values:
  - colour outputs 0
  - hsync=1, vsync=1
  - board_addr=0
  - col_valid=0, row_valid=0
  - frame_cnt=0, phase=0
  - all pipeline valid bits 0
- Reset mid-frame:
  - Output is blank until the pipeline refills.
  - in_board stays 0 until the next ORIGIN_Y line of the next frame. No partial board is drawn.
- Simultaneous frame tick and wrap: the phase toggles exactly once.

## Structure
- Shared package gomoku_pkg:
  - cell_e enum: EMPTY=0, BLACK=1, WHITE=2
  - rgb12_t packed struct
  - colour constants: COL_BG, COL_WOOD, COL_GRID, COL_BLACK, COL_WHITE, COL_CURSOR
- One sub-module, cell_tracker, parametrised by ORIGIN, CELL_PX and BOARD_N. It is instantiated twice: once for columns (strobe pix_en) and once for rows (strobe pix_en & h_cnt==0).

## Test plan
- Defaults, continuous pix_en, h=208, v=100 → board_addr=33 (row 2, col 3); with board_data=1, colour 0x111 appears 3 strobes later, with hsync and vsync equally delayed.
- Same pixel with board_data=2 → 0xFFF. With board_data=3 → 0xC90. Pixel h=110, v=30 → 0x000 (grid). Pixel h=50, v=50 → 0x234.
- cursor_en=1, cursor (2,3), h=195, v=100 (xoff=1) → 0xF00 in phase 0. After 30 vsync rising edges → 0xC90.
- Random pix_en gaps of 0–3 clocks over a full frame → pixel stream identical to the gap-free reference model.
- Assert rst at h=300, v=200 for one clock → next output 0x000 with hsync=1. No board pixels until the frame after reset; the next frame renders correctly.
- valid_in=0 inside the board region → colour 0x000 regardless of board_data.
